// File: rtl/ped_request_ctrl.sv
// Pedestrian push-button front end: synchronise, debounce, latch a crossing
// request until the light controller serves it, blink WAIT, enforce lockout.
module ped_request_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 8,
    parameter int BLINK_CYCLES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic       ped_phase,
    output logic       ped_req,
    output logic       wait_led,
    output logic [7:0] press_count
);

    localparam int DCNT_W = (DEBOUNCE_CYCLES + 1 > 2) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int LCNT_W = (LOCKOUT_CYCLES + 1 > 2) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
    localparam int BCNT_W = (BLINK_CYCLES + 1 > 2) ? $clog2(BLINK_CYCLES + 1) : 1;
    localparam int RCNT_W = $clog2(DEBOUNCE_CYCLES + 3);

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LCNT_W-1:0] LCNT_LOAD = LCNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [BCNT_W-1:0] BCNT_LOAD = BCNT_W'(BLINK_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RCNT_DONE = RCNT_W'(DEBOUNCE_CYCLES + 2);

    typedef enum logic [1:0] {IDLE, PENDING, SERVING, LOCKOUT} state_t;

    logic              sync1_q, sync2_q;
    logic              btn_s;
    logic              db_q, db_d, db_dly_q;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              armed_q;
    logic              press;
    logic [7:0]        press_count_q;
    state_t            state_q;
    logic [LCNT_W-1:0] lcnt_q;
    logic [BCNT_W-1:0] bcnt_q;
    logic              deferred_q;
    logic              ped_req_q, wait_led_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    assign btn_s = ~sync2_q;

    always_comb begin
        db_d   = db_q;
        dcnt_d = '0;
        if (btn_s != db_q) begin
            if (dcnt_q == DCNT_LAST) db_d = btn_s;
            else                     dcnt_d = dcnt_q + 1'b1;
        end
    end

    // The two sync flops can fake at most two released cycles after reset, so
    // arming needs DEBOUNCE_CYCLES+2 released cycles: a button still held
    // through reset never produces an event until it has truly been let go.
    always_comb begin
        rcnt_d = rcnt_q;
        if (btn_s)                  rcnt_d = '0;
        else if (rcnt_q != RCNT_DONE) rcnt_d = rcnt_q + 1'b1;
    end

    assign press = db_q & ~db_dly_q & armed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q          <= 1'b0;
            db_dly_q      <= 1'b0;
            dcnt_q        <= '0;
            rcnt_q        <= '0;
            armed_q       <= 1'b0;
            press_count_q <= 8'd0;
        end else begin
            db_q     <= db_d;
            db_dly_q <= db_q;
            dcnt_q   <= dcnt_d;
            rcnt_q   <= rcnt_d;
            if (rcnt_q == RCNT_DONE) armed_q <= 1'b1;
            if (press && press_count_q != 8'hFF) press_count_q <= press_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lcnt_q     <= '0;
            bcnt_q     <= '0;
            deferred_q <= 1'b0;
            ped_req_q  <= 1'b0;
            wait_led_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ped_phase) begin
                        state_q <= SERVING;
                    end else if (press) begin
                        state_q    <= PENDING;
                        ped_req_q  <= 1'b1;
                        wait_led_q <= 1'b1;
                        bcnt_q     <= BCNT_LOAD;
                    end
                end
                PENDING: begin
                    if (ped_phase) begin
                        state_q    <= SERVING;
                        ped_req_q  <= 1'b0;
                        wait_led_q <= 1'b0;
                    end else if (bcnt_q == '0) begin
                        wait_led_q <= ~wait_led_q;
                        bcnt_q     <= BCNT_LOAD;
                    end else begin
                        bcnt_q <= bcnt_q - 1'b1;
                    end
                end
                SERVING: begin
                    if (!ped_phase) begin
                        state_q    <= LOCKOUT;
                        lcnt_q     <= LCNT_LOAD;
                        deferred_q <= 1'b0;
                    end
                end
                LOCKOUT: begin
                    if (ped_phase) begin
                        state_q    <= SERVING;
                        deferred_q <= 1'b0;
                    end else if (lcnt_q == '0) begin
                        deferred_q <= 1'b0;
                        if (deferred_q || press) begin
                            state_q    <= PENDING;
                            ped_req_q  <= 1'b1;
                            wait_led_q <= 1'b1;
                            bcnt_q     <= BCNT_LOAD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        lcnt_q <= lcnt_q - 1'b1;
                        if (press) deferred_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    ped_req_q  <= 1'b0;
                    wait_led_q <= 1'b0;
                end
            endcase
        end
    end

    assign ped_req     = ped_req_q;
    assign wait_led    = wait_led_q;
    assign press_count = press_count_q;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Directed bench for ped_request_ctrl with the default parameters
// (debounce 4, lockout 8, blink 3); expected values are worked out by hand.
module tb_ped_request_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_n;
    logic       ped_phase;
    logic       ped_req;
    logic       wait_led;
    logic [7:0] press_count;

    int n_cmp = 0;
    int n_mis = 0;

    ped_request_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .LOCKOUT_CYCLES (8),
        .BLINK_CYCLES   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_n      (btn_n),
        .ped_phase  (ped_phase),
        .ped_req    (ped_req),
        .wait_led   (wait_led),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        btn_n     = 1'b1;
        ped_phase = 1'b0;
        #1;
        check_eq("rst_ped_req", ped_req, 0);
        check_eq("rst_wait_led", wait_led, 0);
        check_eq("rst_press_count", press_count, 0);
        tick(2);
        rst = 1'b0;
        tick(10);

        // Bounce: 3 low, 2 high, five times
        for (int i = 0; i < 5; i++) begin
            btn_n = 1'b0; tick(3);
            btn_n = 1'b1; tick(2);
        end
        tick(10);
        check_eq("bounce_ped_req", ped_req, 0);
        check_eq("bounce_count", press_count, 0);

        // Clean press: first sampling edge k, request after edge k+6
        btn_n = 1'b0;
        tick(6);
        check_eq("press_k5_ped_req", ped_req, 0);
        tick(1);
        check_eq("press_k6_ped_req", ped_req, 1);
        check_eq("press_k6_wait_led", wait_led, 1);
        check_eq("press_k6_count", press_count, 1);
        tick(2);
        check_eq("blink_e2", wait_led, 1);
        tick(1);
        check_eq("blink_e3", wait_led, 0);
        tick(2);
        check_eq("blink_e5", wait_led, 0);
        tick(1);
        check_eq("blink_e6", wait_led, 1);
        tick(12);
        check_eq("hold_single_event", press_count, 1);
        btn_n = 1'b1;
        tick(10);

        // Service, then a press while serving is ignored by the FSM
        ped_phase = 1'b1;
        tick(1);
        check_eq("serve_ped_req", ped_req, 0);
        check_eq("serve_wait_led", wait_led, 0);
        btn_n = 1'b0;
        tick(8);
        check_eq("serving_press_ped_req", ped_req, 0);
        check_eq("serving_press_count", press_count, 2);
        btn_n = 1'b1;
        tick(8);

        // Lockout, press lands mid-lockout (deferred)
        ped_phase = 1'b0;
        tick(1);
        btn_n = 1'b0;
        tick(7);
        check_eq("lock_def_s7", ped_req, 0);
        tick(1);
        check_eq("lock_def_s8", ped_req, 1);
        check_eq("lock_def_count", press_count, 3);
        btn_n = 1'b1;
        tick(10);

        // Lockout, press lands on the final lockout cycle
        ped_phase = 1'b1;
        tick(1);
        ped_phase = 1'b0;
        tick(2);
        btn_n = 1'b0;
        tick(6);
        check_eq("lock_final_s7", ped_req, 0);
        tick(1);
        check_eq("lock_final_s8", ped_req, 1);
        check_eq("lock_final_count", press_count, 4);
        btn_n = 1'b1;
        tick(10);

        // Lockout without press returns to IDLE; a later press works normally
        ped_phase = 1'b1;
        tick(1);
        ped_phase = 1'b0;
        tick(10);
        check_eq("lock_idle_ped_req", ped_req, 0);
        btn_n = 1'b0;
        tick(7);
        check_eq("idle_press_ped_req", ped_req, 1);
        check_eq("idle_press_count", press_count, 5);
        btn_n = 1'b1;
        tick(10);

        // Serve, let lockout run out, then an unrequested 5-cycle phase
        ped_phase = 1'b1;
        tick(1);
        ped_phase = 1'b0;
        tick(10);
        ped_phase = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_eq($sformatf("unreq_phase_%0d", i), ped_req, 0);
        end
        ped_phase = 1'b0;
        tick(10);
        check_eq("unreq_after_ped_req", ped_req, 0);
        check_eq("unreq_after_wait_led", wait_led, 0);

        // Press and ped_phase in the same IDLE cycle
        btn_n = 1'b0;
        tick(6);
        ped_phase = 1'b1;
        tick(1);
        check_eq("simul_ped_req", ped_req, 0);
        check_eq("simul_count", press_count, 6);
        ped_phase = 1'b0;
        btn_n     = 1'b1;
        tick(12);
        check_eq("simul_after_ped_req", ped_req, 0);

        // Saturation
        for (int i = 0; i < 260; i++) begin
            btn_n = 1'b0; tick(8);
            btn_n = 1'b1; tick(8);
        end
        check_eq("sat_count", press_count, 255);
        check_eq("sat_ped_req", ped_req, 1);

        // Asynchronous reset while PENDING with the button held
        btn_n = 1'b0;
        tick(3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("async_rst_ped_req", ped_req, 0);
        check_eq("async_rst_wait_led", wait_led, 0);
        check_eq("async_rst_count", press_count, 0);
        tick(2);
        rst = 1'b0;
        tick(20);
        check_eq("held_after_rst_ped_req", ped_req, 0);
        check_eq("held_after_rst_count", press_count, 0);
        btn_n = 1'b1;
        tick(12);
        check_eq("release_after_rst_count", press_count, 0);
        btn_n = 1'b0;
        tick(6);
        check_eq("repress_k5_ped_req", ped_req, 0);
        tick(1);
        check_eq("repress_k6_ped_req", ped_req, 1);
        check_eq("repress_count", press_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ped_request_ctrl.md
# ped_request_ctrl

Pedestrian push-button front end, directly upstream of the crossing light controller. Synchronises and debounces the raw button, latches a crossing request and holds it until the controller starts a pedestrian phase. Also drives a blinking "WAIT" indicator and enforces a lockout after each pedestrian phase. The controller consumes `ped_req` and reports its pedestrian phase back on `ped_phase`.

## Interface

- `DEBOUNCE_CYCLES`, 4: consecutive cycles the synchronised button must differ from its debounced level before that level changes (≥1).
- `LOCKOUT_CYCLES`, 8: cycles after `ped_phase` falls during which no new request is raised (≥1).
- `BLINK_CYCLES`, 3: half-period of `wait_led` in cycles (≥1).

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `btn_n`  in  1  raw push-button, active-low, asynchronous to `clk`
- `ped_phase`  in  1  high while the controller shows pedestrian green or blinking green
- `ped_req`  out  1  pending crossing request, level, held until served
- `wait_led`  out  1  WAIT indicator, blinks while a request is pending
- `press_count`  out  8  debounced press events since reset, saturating

## Operation

- Synchroniser: two flops on `btn_n`, both reset to 1 (released). `btn_s = ~sync2`.
- Debouncer: level `db` (reset 0), counter `dcnt` of width clog2(DEBOUNCE_CYCLES+1) (reset 0).
  - If `btn_s == db`, `dcnt` clears.
  - Otherwise `dcnt` increments. When it would reach DEBOUNCE_CYCLES, `db` takes `btn_s` and `dcnt` clears.
- Press event `press = db & ~db_d`, where `db_d` is `db` registered and reset to 0. The event is one cycle wide.
- `press_count` increments on every press event and saturates at 255.
- State machine. States are IDLE, PENDING, SERVING and LOCKOUT, with reset state IDLE. Priority within each state is as listed:
  - IDLE: `ped_phase`=1 → SERVING (the controller may serve unrequested). Otherwise `press` → PENDING.
  - PENDING: `ped_phase`=1 → SERVING.
  - SERVING: `ped_phase`=0 → LOCKOUT, with `lcnt` loaded to LOCKOUT_CYCLES-1. Presses are ignored here.
  - LOCKOUT:
    - `press` sets the `deferred` flag.
    - If `ped_phase`=1 → SERVING and `deferred` clears.
    - Else, when `lcnt`==0: go to PENDING if `deferred` or `press` is set this cycle, otherwise to IDLE. `deferred` clears in both cases.
    - Otherwise `lcnt` decrements.
- Outputs:
  - `ped_req` = (state==PENDING), decoded from the registered state.
  - `wait_led` = 0 outside PENDING. On entry to PENDING it is 1 and toggles every BLINK_CYCLES cycles via the blink counter `bcnt`, which reloads on entry.
- Reset mid-operation: every register returns to its reset value immediately. Any pending request is lost.

## Timing

- Reset values: `ped_req`=0, `wait_led`=0, `press_count`=0.
- Press latency. Let edge k be the first rising edge that samples `btn_n`=0, with the button held stable.
  - `db` rises after edge k+DEBOUNCE_CYCLES+1.
  - `ped_req` and `wait_led` rise after edge k+DEBOUNCE_CYCLES+2.
  - `press_count` updates at that same edge.
- Bounce shorter than DEBOUNCE_CYCLES synchronised cycles produces no event. Release is debounced identically.
- `ped_phase` to `ped_req`: `ped_req` falls after the first edge sampling `ped_phase`=1.
- Lockout: after the edge sampling `ped_phase`=0 in SERVING, exactly LOCKOUT_CYCLES further edges pass before leaving LOCKOUT.
- Simultaneous events:
  - `press` and `ped_phase`=1 in the same cycle in IDLE → SERVING, no request; `press_count` still increments.
  - `press` on the final LOCKOUT cycle → PENDING.
- Holding the button produces a single event. A new press needs a debounced release first.

## Test plan

- Clean press, DEBOUNCE_CYCLES=4: `btn_n` low before edge 10 and held → `ped_req`=1 and `wait_led`=1 after edge 16, `press_count`=1; `wait_led` toggles every 3 cycles.
- Bounce: `btn_n` pulses low for 3 cycles, repeated 5 times with 2-cycle highs between → `ped_req` stays 0, `press_count`=0.
- Service: from PENDING, raise `ped_phase` → `ped_req`=0 and `wait_led`=0 next edge. Press during SERVING → no change.
- Lockout, LOCKOUT_CYCLES=8: drop `ped_phase`, press at lockout cycle 2 → `ped_req` rises exactly 8 edges after `ped_phase` was sampled low. Without a press → IDLE, `ped_req`=0.
- Unrequested phase: in IDLE, pulse `ped_phase` 5 cycles → SERVING then LOCKOUT, `ped_req` never asserts.
- Saturation and reset: 260 clean presses → `press_count`=255. Assert `rst` while PENDING → all outputs 0 immediately; the held button yields no event until released and pressed again.
